// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative signed multiply (radix-2 Booth) / divide (non-restoring) unit.
// Define DIV_ZERO_TRAP_EN to end a divide by zero after one cycle with div_zero raised.
module seq_muldiv #(
  parameter int         WIDTH  = 32,
  parameter logic [4:0] MUL_OP = 5'b01111,
  parameter logic [4:0] DIV_OP = 5'b10000
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state, state_nx;
  // acc carries two guard bits so both Booth (-min) and the shifted remainder fit
  logic [WIDTH+1:0] acc, m, booth_sum, r_sh, r_new;
  logic [WIDTH-1:0] q, a_reg, r_fix, qs, rs;
  logic [CW-1:0]    cnt;
  logic             qm1, sa, sb, accept, last, b_zero;
  assign accept    = start && (opcode == MUL_OP || opcode == DIV_OP);
  assign last      = cnt == CW'(WIDTH);
  assign b_zero    = m == '0;
  assign booth_sum = ({q[0], qm1} == 2'b01) ? acc + m : ({q[0], qm1} == 2'b10) ? acc - m : acc;
  assign r_sh      = {acc[WIDTH:0], q[WIDTH-1]};
  assign r_new     = acc[WIDTH+1] ? r_sh + m : r_sh - m;
  assign r_fix     = acc[WIDTH-1:0] + (acc[WIDTH+1] ? m[WIDTH-1:0] : '0);
  assign qs        = (sa ^ sb) ? -q : q;
  assign rs        = sa ? -r_fix : r_fix;
  always_comb begin
    state_nx = state;
    busy     = state != IDLE;
    done     = state == DONE;
    case (state)
      IDLE:    state_nx = !accept ? IDLE : (opcode == MUL_OP) ? MUL : DIV;
      MUL:     state_nx = last ? DONE : MUL;
`ifdef DIV_ZERO_TRAP_EN
      DIV:     state_nx = b_zero ? DONE : last ? FIX : DIV;
`else
      DIV:     state_nx = last ? FIX : DIV;
`endif
      FIX:     state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      acc    <= '0;
      m      <= '0;
      q      <= '0;
      qm1    <= 1'b0;
      a_reg  <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          a_reg <= A;
          sa    <= A[WIDTH-1];
          sb    <= B[WIDTH-1];
          acc   <= '0;
          qm1   <= 1'b0;
          cnt   <= '0;
          q     <= (opcode == MUL_OP) ? B : (A[WIDTH-1] ? -A : A);
          m     <= (opcode == MUL_OP) ? {{2{A[WIDTH-1]}}, A} : {2'b00, B[WIDTH-1] ? -B : B};
        end
        MUL: if (last) result <= {acc[WIDTH-1:0], q};
        else begin
          acc <= {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
          q   <= {booth_sum[0], q[WIDTH-1:1]};
          qm1 <= q[0];
          cnt <= cnt + 1'b1;
        end
        DIV:
`ifdef DIV_ZERO_TRAP_EN
          if (b_zero) result <= {a_reg, {WIDTH{1'b1}}};
          else
`endif
          if (!last) begin
            acc <= r_new;
            q   <= {q[WIDTH-2:0], ~r_new[WIDTH+1]};
            cnt <= cnt + 1'b1;
          end
        FIX: result <= b_zero ? {a_reg, {WIDTH{1'b1}}} : {rs, qs};
        default: ;
      endcase
    end
  end
`ifdef DIV_ZERO_TRAP_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) div_zero <= 1'b0;
    else if (state == IDLE && accept) div_zero <= 1'b0;
    else if (state == DIV && b_zero) div_zero <= 1'b1;
  end
`else
  assign div_zero = 1'b0;
`endif
endmodule

// File: tb/tb_seq_muldiv.sv
// tb_seq_muldiv: directed vectors for seq_muldiv, latency and result checks.
module tb_seq_muldiv;
  localparam logic [4:0] MUL_OP = 5'b01111;
  localparam logic [4:0] DIV_OP = 5'b10000;
  logic        clk = 1'b0, clr_n = 1'b0, start = 1'b0;
  logic [4:0]  opcode = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero;
  logic [63:0] result;
  int          checks = 0, errors = 0;
  int          lat, dones, done_at;
  logic        dz;
  seq_muldiv dut (
    .clk(clk), .clr_n(clr_n), .start(start), .opcode(opcode), .A(a), .B(b),
    .busy(busy), .done(done), .result(result), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                     output int l, output logic z);
    @(negedge clk);
    start = 1'b1; opcode = op; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    l = -1;
    z = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) begin
        l = n;
        z = div_zero;
        break;
      end
    end
  endtask
  initial begin
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'h0);
    check("reset_dz", 64'(div_zero), 64'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    run(MUL_OP, 32'd7, -32'sd3, lat, dz);
    check("mul_7x-3_lat", 64'(lat), 64'd33);
    check("mul_7x-3", result, 64'hFFFFFFFF_FFFFFFEB);
    run(MUL_OP, 32'h7FFFFFFF, 32'h7FFFFFFF, lat, dz);
    check("mul_max_lat", 64'(lat), 64'd33);
    check("mul_max", result, 64'h3FFFFFFF_00000001);
    run(DIV_OP, -32'sd7, 32'd2, lat, dz);
    check("div_-7/2_lat", 64'(lat), 64'd34);
    check("div_-7/2", result, 64'hFFFFFFFF_FFFFFFFD);
    run(DIV_OP, 32'd100, 32'd7, lat, dz);
    check("div_100/7_lat", 64'(lat), 64'd34);
    check("div_100/7", result, 64'h00000002_0000000E);
    // unrecognised opcode must be ignored and result must hold
    @(negedge clk);
    start = 1'b1; opcode = 5'b00011; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    check("bad_op_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("hold_result", result, 64'h00000002_0000000E);
    run(DIV_OP, 32'h80000000, 32'hFFFFFFFF, lat, dz);
    check("div_ovf", result, 64'h00000000_80000000);
    check("div_ovf_dz", 64'(dz), 64'd0);
    run(DIV_OP, 32'd5, 32'd0, lat, dz);
    check("div0_result", result, 64'h00000005_FFFFFFFF);
`ifdef DIV_ZERO_TRAP_EN
    check("div0_lat", 64'(lat), 64'd1);
    check("div0_dz", 64'(dz), 64'd1);
`else
    check("div0_lat", 64'(lat), 64'd34);
    check("div0_dz", 64'(dz), 64'd0);
`endif
    // restarts during a running multiply and in its DONE cycle are dropped
    @(negedge clk);
    start = 1'b1; opcode = MUL_OP; a = 32'd6; b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    done_at = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        done_at = n;
      end
      if (n == 34) check("restart_idle", 64'(busy), 64'd0);
      start = (n == 5 || n == 33);
      a = 32'd100; b = 32'd100;
    end
    check("restart_dones", 64'(dones), 64'd1);
    check("restart_done_at", 64'(done_at), 64'd33);
    check("restart_result", result, 64'd30);
    // asynchronous clear in the middle of a divide
    @(negedge clk);
    start = 1'b1; opcode = DIV_OP; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    clr_n = 1'b0;
    #1;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_result", result, 64'h0);
    @(negedge clk);
    clr_n = 1'b1;
    run(MUL_OP, 32'd3, 32'd4, lat, dz);
    check("post_clr_lat", 64'(lat), 64'd33);
    check("post_clr_mul", result, 64'd12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
